// File: rtl/icache_pkg.sv
// Shared fetch-pipeline constants for the instruction cache.
// Holds the cache controller state encoding and the fetch-word geometry.
package icache_pkg;

  localparam int FETCH_W          = 32;
  localparam int ADDR_W           = 32;
  localparam int WORD_OFFSET_BITS = 2;

  typedef enum logic [1:0] {
    IC_IDLE   = 2'd0,
    IC_LOOKUP = 2'd1,
    IC_MISS   = 2'd2
  } icache_state_e;

  // Clears the byte-offset bits so refills always target a whole word.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped tag/data/valid storage for the instruction cache.
// Writes are synchronous; reads are combinational by line index.
// Only the valid bits are reset, so stale tag/data are never trusted.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] idx_i,
  input  logic [TAG_BITS-1:0]   wtag_i,
  input  logic [FETCH_W-1:0]    wdata_i,
  output logic                  rvalid_o,
  output logic [TAG_BITS-1:0]   rtag_o,
  output logic [FETCH_W-1:0]    rdata_o
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [FETCH_W-1:0]  data_q [LINES];

  // Valid bits: cleared on reset, set when a refill lands in a line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data payload: no reset needed, guarded by the valid bit.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[idx_i]  <= wtag_i;
      data_q[idx_i] <= wdata_i;
    end
  end

  assign rvalid_o = valid_q[idx_i];
  assign rtag_o   = tag_q[idx_i];
  assign rdata_o  = data_q[idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped single-word-line instruction cache with a blocking refill path.
// Optional feature: define ICACHE_PERF_EN to add hit_count/miss_count outputs.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_pc,
  output logic               fetch_ready,
  input  logic               flush,
  output logic               inst_valid,
  output logic [FETCH_W-1:0] inst,
  output logic               mem_fetch_enable,
  output logic [ADDR_W-1:0]  mem_inst_addr,
  input  logic               mem_valid,
  input  logic [FETCH_W-1:0] mem_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);

  localparam int TAG_BITS = ADDR_W - INDEX_BITS - WORD_OFFSET_BITS;

  icache_state_e      state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               inst_valid_q;
  logic [FETCH_W-1:0] inst_q;
  logic               mem_fetch_enable_q;
  logic [ADDR_W-1:0]  mem_inst_addr_q;
  logic               flush_pend_q;

  logic [INDEX_BITS-1:0] line_idx;
  logic [TAG_BITS-1:0]   line_tag;
  logic                  arr_valid;
  logic [TAG_BITS-1:0]   arr_tag;
  logic [FETCH_W-1:0]    arr_data;
  logic                  hit;
  logic                  accept;
  logic                  refill_we;

  assign line_idx    = pc_q[INDEX_BITS+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];
  assign line_tag    = pc_q[ADDR_W-1:INDEX_BITS+WORD_OFFSET_BITS];
  assign hit         = arr_valid && (arr_tag == line_tag);
  assign fetch_ready = rdy && (state_q == IC_IDLE) && !flush;
  assign accept      = fetch_req && fetch_ready;
  assign refill_we   = rdy && (state_q == IC_MISS) && mem_valid;

  icache_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (refill_we),
    .idx_i   (line_idx),
    .wtag_i  (line_tag),
    .wdata_i (mem_data),
    .rvalid_o(arr_valid),
    .rtag_o  (arr_tag),
    .rdata_o (arr_data)
  );

  // Controller FSM with registered outputs; rdy low holds everything in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= IC_IDLE;
      pc_q               <= '0;
      inst_valid_q       <= 1'b0;
      inst_q             <= '0;
      mem_fetch_enable_q <= 1'b0;
      mem_inst_addr_q    <= '0;
      flush_pend_q       <= 1'b0;
    end else if (rdy) begin
      inst_valid_q <= 1'b0;
      case (state_q)
        IC_IDLE: begin
          if (accept) begin
            pc_q    <= fetch_pc;
            state_q <= IC_LOOKUP;
          end
        end
        IC_LOOKUP: begin
          if (flush) begin
            state_q <= IC_IDLE;
          end else if (hit) begin
            inst_valid_q <= 1'b1;
            inst_q       <= arr_data;
            state_q      <= IC_IDLE;
          end else begin
            mem_fetch_enable_q <= 1'b1;
            mem_inst_addr_q    <= word_align(pc_q);
            state_q            <= IC_MISS;
          end
        end
        IC_MISS: begin
          if (mem_valid) begin
            mem_fetch_enable_q <= 1'b0;
            flush_pend_q       <= 1'b0;
            state_q            <= IC_IDLE;
            if (!(flush_pend_q || flush)) begin
              inst_valid_q <= 1'b1;
              inst_q       <= mem_data;
            end
          end else if (flush) begin
            flush_pend_q <= 1'b1;
          end
        end
        default: state_q <= IC_IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  // Lookup outcome counters; flushed lookups count as neither.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (rdy && (state_q == IC_LOOKUP) && !flush) begin
      if (hit) begin
        hit_count_q <= hit_count_q + 32'd1;
      end else begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

  assign inst_valid       = inst_valid_q;
  assign inst             = inst_q;
  assign mem_fetch_enable = mem_fetch_enable_q;
  assign mem_inst_addr    = mem_inst_addr_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache (default build, INDEX_BITS=6).
// Stimulus pushes expected instruction words; a negedge monitor pops and compares.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        flush;
  logic        inst_valid;
  logic [31:0] inst;
  logic        mem_fetch_enable;
  logic [31:0] mem_inst_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  int          total = 0;
  int          bad = 0;
  logic [31:0] expQ[$];
  logic [31:0] expWord;
  logic        prevValid = 1'b0;
  bit          ok;

  icache #(.INDEX_BITS(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .fetch_req       (fetch_req),
    .fetch_pc        (fetch_pc),
    .fetch_ready     (fetch_ready),
    .flush           (flush),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .mem_fetch_enable(mem_fetch_enable),
    .mem_inst_addr   (mem_inst_addr),
    .mem_valid       (mem_valid),
    .mem_data        (mem_data)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Hard stop so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every delivered instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (inst_valid === 1'b1) begin
        checkOutput("no_back_to_back", {31'b0, prevValid}, 32'd0);
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_inst: got 0x%08h want none", inst);
        end else begin
          expWord = expQ.pop_front();
          checkOutput("inst_word", inst, expWord);
        end
      end
      prevValid = inst_valid;
    end else begin
      prevValid = 1'b0;
    end
  end

  // Present one request for one clock; caller is just past a rising edge with the cache idle.
  task automatic applyStimulus(input logic [31:0] pc);
    checkOutput("fetch_ready_idle", {31'b0, fetch_ready}, 32'd1);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
  endtask

  task automatic waitRefill(input logic [31:0] pc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_fetch_enable === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("refill_start", {31'b0, seen}, 32'd1);
    if (seen) checkOutput("refill_addr", mem_inst_addr, pc & 32'hFFFF_FFFC);
  endtask

  task automatic runHit(input logic [31:0] pc, input logic [31:0] data);
    expQ.push_back(data);
    applyStimulus(pc);
    @(negedge clk);
    checkOutput("hit_lookup_quiet", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    checkOutput("hit_latency", {31'b0, inst_valid}, 32'd1);
    checkOutput("hit_no_refill", {31'b0, mem_fetch_enable}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic runMiss(input logic [31:0] pc, input logic [31:0] data, input int delay,
                         input int flushAt, input int rdyAt, input bit deliver);
    bit seen;
    if (deliver) expQ.push_back(data);
    applyStimulus(pc);
    waitRefill(pc, seen);
    for (int i = 1; i <= delay; i++) begin
      @(posedge clk);
      #1;
      flush = (i == flushAt);
      if (i == rdyAt) begin
        rdy = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          checkOutput("frozen_mfe", {31'b0, mem_fetch_enable}, 32'd1);
          checkOutput("frozen_addr", mem_inst_addr, pc & 32'hFFFF_FFFC);
          checkOutput("frozen_valid", {31'b0, inst_valid}, 32'd0);
          @(posedge clk);
          #1;
        end
        rdy = 1'b1;
      end
      @(negedge clk);
      checkOutput("refill_hold", {31'b0, mem_fetch_enable}, 32'd1);
      checkOutput("refill_addr_hold", mem_inst_addr, pc & 32'hFFFF_FFFC);
    end
    flush     = 1'b0;
    mem_valid = 1'b1;
    mem_data  = data;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    mem_data  = '0;
    @(negedge clk);
    checkOutput("refill_done", {31'b0, mem_fetch_enable}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    rdy       = 1'b1;
    fetch_req = 1'b0;
    fetch_pc  = '0;
    flush     = 1'b0;
    mem_valid = 1'b0;
    mem_data  = '0;
    #1;
    checkOutput("reset_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("reset_inst", inst, 32'd0);
    checkOutput("reset_mfe", {31'b0, mem_fetch_enable}, 32'd0);
    checkOutput("reset_addr", mem_inst_addr, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Cold miss, conflict eviction and re-miss.
    runMiss(32'h0000_0010, 32'h0000_0513, 5, 0, 0, 1'b1);
    runHit (32'h0000_0010, 32'h0000_0513);
    runMiss(32'h0000_0110, 32'hAAAA_0001, 2, 0, 0, 1'b1);
    runHit (32'h0000_0110, 32'hAAAA_0001);
    runMiss(32'h0000_0010, 32'h0000_0513, 1, 0, 0, 1'b1);

    // Flush during refill: nothing delivered, but the line is filled.
    runMiss(32'h0000_0024, 32'h1234_5678, 4, 2, 0, 1'b0);
    runHit (32'h0000_0026, 32'h1234_5678);

    // rdy low for three cycles mid-refill.
    runMiss(32'h0000_0038, 32'hCAFE_F00D, 5, 0, 2, 1'b1);
    runHit (32'h0000_0038, 32'hCAFE_F00D);

    // Flush during lookup of a cold line: no refill, back to idle.
    applyStimulus(32'h0000_0040);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("lookup_flush_mfe", {31'b0, mem_fetch_enable}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lookup_flush_idle", {31'b0, fetch_ready}, 32'd1);
    @(negedge clk);
    checkOutput("lookup_flush_mfe_late", {31'b0, mem_fetch_enable}, 32'd0);
    @(posedge clk);
    #1;

    // Flush together with a request: the request is refused.
    flush     = 1'b1;
    fetch_req = 1'b1;
    fetch_pc  = 32'h0000_0044;
    #1;
    checkOutput("flush_blocks_ready", {31'b0, fetch_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    fetch_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("flush_req_no_refill", {31'b0, mem_fetch_enable}, 32'd0);
    @(posedge clk);
    #1;

    // Stray mem_valid while idle must not disturb anything.
    mem_valid = 1'b1;
    mem_data  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    mem_data  = '0;
    @(negedge clk);
    checkOutput("stray_mem_valid_mfe", {31'b0, mem_fetch_enable}, 32'd0);
    @(posedge clk);
    #1;
    runHit(32'h0000_0010, 32'h0000_0513);

    // Asynchronous reset in the middle of a refill.
    applyStimulus(32'h0000_0050);
    waitRefill(32'h0000_0050, ok);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_mfe", {31'b0, mem_fetch_enable}, 32'd0);
    checkOutput("async_reset_addr", mem_inst_addr, 32'd0);
    checkOutput("async_reset_ready", {31'b0, fetch_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    runMiss(32'h0000_0050, 32'h0BAD_CAFE, 3, 0, 0, 1'b1);
    runMiss(32'h0000_0010, 32'h0000_0513, 1, 0, 0, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_BITS, default 6, line-index width (2**INDEX_BITS direct-mapped lines, one 32-bit word each).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-004 rdy  input  1  global ready; 0 freezes all state and outputs.
REQ-005 fetch_req  input  1  fetcher requests instruction at fetch_pc.
REQ-006 fetch_pc  input  32  byte address of requested instruction.
REQ-007 fetch_ready  output  1  cache can accept a request this cycle.
REQ-008 flush  input  1  discard any pending delivery (branch redirect).
REQ-009 inst_valid  output  1  one-cycle pulse, inst holds requested instruction.
REQ-010 inst  output  32  instruction word.
REQ-011 mem_fetch_enable  output  1  refill request to memory controller, held until mem_valid.
REQ-012 mem_inst_addr  output  32  word-aligned refill address.
REQ-013 mem_valid  input  1  one-cycle pulse, mem_data valid.
REQ-014 mem_data  input  32  refill word, little-endian assembled.

Function
REQ-015 Address split: offset=pc[1:0] (ignored), index=pc[INDEX_BITS+1:2], tag=pc[31:INDEX_BITS+2].
REQ-016 States IDLE, LOOKUP, MISS; request accepted when fetch_req && fetch_ready; fetch_ready=1 only in IDLE with flush=0.
REQ-017 Accept in IDLE: latch pc, go LOOKUP.
REQ-018 LOOKUP hit (valid[index] && tag match): inst_valid=1, inst=line data next cycle, go IDLE; hit latency 2 cycles request-to-inst_valid.
REQ-019 LOOKUP miss: mem_fetch_enable=1, mem_inst_addr={pc[31:2],2'b00}, go MISS.
REQ-020 MISS: hold mem_fetch_enable and mem_inst_addr stable until mem_valid; on mem_valid write data, tag, set valid, deassert mem_fetch_enable next edge, pulse inst_valid with mem_data, go IDLE.
REQ-021 flush in LOOKUP: no inst_valid, no refill, go IDLE.
REQ-022 flush in MISS: refill continues to completion (controller cannot abort) and line is written, but inst_valid is suppressed; flush is remembered until mem_valid.
REQ-023 flush and fetch_req same cycle: request not accepted.
REQ-024 mem_valid outside MISS is ignored.
REQ-025 rdy=0: no state, array, or output change; a mem_valid arriving with rdy=0 is lost by the controller contract and need not be handled.
REQ-026 inst_valid never asserts two consecutive cycles.

Reset
REQ-027 On rst=0 asynchronously: state=IDLE, all valid bits cleared, inst_valid=0, inst=0, mem_fetch_enable=0, mem_inst_addr=0, pending-flush flag cleared; data/tag arrays need not reset.
REQ-028 Reset mid-MISS abandons the refill; the following refill request restarts from IDLE.

Configuration
REQ-029 Macro ICACHE_PERF_EN defined: adds outputs hit_count and miss_count (32-bit, reset 0, incremented on each LOOKUP hit / miss, wrap at 2**32); undefined: ports and counters absent, behaviour otherwise identical.

Structure
REQ-030 State encodings and the fetch-word width belong in the shared constants header with other pipeline constants.
REQ-031 Tag/data/valid storage is one sub-module icache_array (sync write, combinational read by index).

Verification
REQ-032 Cold miss: req pc=0x0000_0010, mem_valid with 0x0000_0513 after 5 cycles -> mem_inst_addr=0x10 held, inst_valid one pulse with inst=0x0000_0513.
REQ-033 Hit: repeat pc=0x10 -> inst_valid 2 cycles after accept, mem_fetch_enable stays 0.
REQ-034 Conflict: pc=0x10 then pc=0x110 (INDEX_BITS=6) -> second misses, evicts; third access to 0x10 misses again.
REQ-035 Flush mid-MISS: flush=1 at cycle 2 of MISS -> no inst_valid, line written, later pc hit returns refilled word.
REQ-036 rdy=0 for 3 cycles during MISS -> outputs frozen, completion resumes unchanged after rdy=1.
REQ-037 Async reset during MISS -> mem_fetch_enable=0 immediately, subsequent access to same pc misses.
